// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one line-wide memory port between ICache and DCache refills
module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int DCACHE_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t            state_q;
  logic              last_d_q;   // 1: the most recent grant went to the DCache
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic              grant_i;
  logic              grant_d;
  logic              idle;

  // Pick the winner among current requesters; on a tie either DCache always wins or the
  // requester that did not win last time does.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req && i_req) begin
      if ((DCACHE_PRIO != 0) || !last_d_q) grant_d = 1'b1;
      else                                 grant_i = 1'b1;
    end else begin
      grant_d = d_req;
      grant_i = i_req;
    end
  end

  // Reset wins the edge, so no request may look accepted while it is asserted.
  assign idle    = (state_q == IDLE) && !rst;
  assign i_ready = idle && grant_i;
  assign d_ready = idle && grant_d;

  // Transaction FSM: latch the winner on grant, hold it on memory until ack, pulse rvalid once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            last_d_q    <= 1'b1;
            state_q     <= BUSY_D;
          end else if (grant_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            last_d_q    <= 1'b0;
            state_q     <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            i_rdata_q  <= mem_rdata;
            i_rvalid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= DONE_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            // A write completion carries no line, so the last read line is kept.
            if (!mem_we_q) d_rdata_q <= mem_rdata;
            d_rvalid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= DONE_D;
          end
        end
        DONE_I: begin
          i_rvalid_q <= 1'b0;
          state_q    <= IDLE;
        end
        DONE_D: begin
          d_rvalid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          mem_req_q  <= 1'b0;
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam logic [127:0] L1  = 128'h1111_0000_2222_0000_3333_0000_4444_0001;
  localparam logic [127:0] L2  = 128'h5555_0000_6666_0000_7777_0000_8888_0002;
  localparam logic [127:0] L3  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L4  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [127:0] L5  = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
  localparam logic [127:0] L6  = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
  localparam logic [127:0] LDB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] LA5 = {16{8'hA5}};

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we, mem_ack;
  logic [31:0]  i_addr, d_addr;
  logic [127:0] d_wdata, mem_rdata;

  logic         p_i_ready, p_i_rvalid, p_d_ready, p_d_rvalid, p_mem_req, p_mem_we;
  logic [127:0] p_i_rdata, p_d_rdata, p_mem_wdata;
  logic [31:0]  p_mem_addr;
  logic         r_i_ready, r_i_rvalid, r_d_ready, r_d_rvalid, r_mem_req, r_mem_we;
  logic [127:0] r_i_rdata, r_d_rdata, r_mem_wdata;
  logic [31:0]  r_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .DCACHE_PRIO(1)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(p_i_ready), .i_rvalid(p_i_rvalid), .i_rdata(p_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(p_d_ready), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
    .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .DCACHE_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(r_i_ready), .i_rvalid(r_i_rvalid), .i_rdata(r_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(r_d_ready), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
    .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    next_cycle();
    next_cycle(); mid();
    chk("rst_mem_req", p_mem_req, 0);
    chk("rst_mem_addr", p_mem_addr, 0);
    chk("rst_i_rdata", p_i_rdata, 0);
    chk("rst_d_rvalid", p_d_rvalid, 0);

    // 1: simultaneous D read 0x100 and I read 0x200, ack after 3 busy cycles
    next_cycle(); rst = 0; d_req = 1; d_addr = 32'h100; i_req = 1; i_addr = 32'h200; mid();
    chk("t1_d_ready_c0", p_d_ready, 1);
    chk("t1_i_ready_c0", p_i_ready, 0);
    chk("t1_rr_d_ready_c0", r_d_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); d_req = 0; mem_ack = (c == 3); mem_rdata = L1; mid();
      chk("t1_mem_req_busy", p_mem_req, 1);
      chk("t1_mem_addr_busy", p_mem_addr, 32'h100);
      chk("t1_i_ready_busy", p_i_ready, 0);
    end
    next_cycle(); mem_ack = 0; mid();
    chk("t1_d_rvalid_c4", p_d_rvalid, 1);
    chk("t1_d_rdata_c4", p_d_rdata, L1);
    chk("t1_mem_req_c4", p_mem_req, 0);
    chk("t1_i_ready_c4", p_i_ready, 0);
    next_cycle(); mid();
    chk("t1_i_ready_c5", p_i_ready, 1);
    chk("t1_d_rvalid_c5", p_d_rvalid, 0);
    next_cycle(); i_req = 0; mem_ack = 1; mem_rdata = L2; mid();
    chk("t1_mem_req_c6", p_mem_req, 1);
    chk("t1_mem_addr_c6", p_mem_addr, 32'h200);
    chk("t1_mem_we_c6", p_mem_we, 0);
    next_cycle(); mem_ack = 0; mid();
    chk("t1_i_rvalid", p_i_rvalid, 1);
    chk("t1_i_rdata", p_i_rdata, L2);
    next_cycle(); mid();
    chk("t1_i_rvalid_drop", p_i_rvalid, 0);

    // 2: both requesters held high; round-robin alternates D,I,D,I, priority mode always D
    mem_rdata = L3;
    for (int g = 0; g < 4; g++) begin
      next_cycle(); d_req = 1; i_req = 1; mem_ack = 0; mid();
      chk("t2_rr_d_ready", r_d_ready, (g % 2 == 0));
      chk("t2_rr_i_ready", r_i_ready, (g % 2 == 1));
      chk("t2_prio_d_ready", p_d_ready, 1);
      chk("t2_prio_i_ready", p_i_ready, 0);
      next_cycle(); mem_ack = 1; if (g == 3) begin d_req = 0; i_req = 0; end mid();
      chk("t2_busy_no_ready", r_d_ready | r_i_ready, 0);
      next_cycle(); mem_ack = 0; mid();
      chk("t2_rr_d_rvalid", r_d_rvalid, (g % 2 == 0));
      chk("t2_rr_i_rvalid", r_i_rvalid, (g % 2 == 1));
      chk("t2_done_no_ready", p_d_ready | p_i_ready, 0);
    end

    // 3: D write, ack in the first busy cycle
    next_cycle(); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = LA5; mid();
    chk("t3_d_ready", p_d_ready, 1);
    next_cycle(); d_req = 0; d_we = 0; mem_ack = 1; mem_rdata = L4; mid();
    chk("t3_mem_we", p_mem_we, 1);
    chk("t3_mem_wdata", p_mem_wdata, LA5);
    chk("t3_mem_addr", p_mem_addr, 32'h40);
    next_cycle(); mem_ack = 0; mid();
    chk("t3_d_rvalid", p_d_rvalid, 1);
    chk("t3_d_rdata_kept", p_d_rdata, L3);
    chk("t3_mem_req_drop", p_mem_req, 0);
    next_cycle(); mid();
    chk("t3_d_rvalid_pulse", p_d_rvalid, 0);

    // 4: I read, ack at cycle 2
    next_cycle(); i_req = 1; i_addr = 32'h300; mid();
    chk("t4_i_ready", p_i_ready, 1);
    next_cycle(); i_req = 0; mem_rdata = LDB; mid();
    chk("t4_mem_req", p_mem_req, 1);
    chk("t4_d_rvalid_c1", p_d_rvalid, 0);
    next_cycle(); mem_ack = 1; mid();
    chk("t4_d_rvalid_c2", p_d_rvalid, 0);
    next_cycle(); mem_ack = 0; mid();
    chk("t4_i_rvalid", p_i_rvalid, 1);
    chk("t4_i_rdata", p_i_rdata, LDB);
    chk("t4_d_rvalid_c3", p_d_rvalid, 0);
    next_cycle(); mid();
    chk("t4_i_rvalid_pulse", p_i_rvalid, 0);
    chk("t4_d_rvalid_c4", p_d_rvalid, 0);

    // 5: reset during BUSY_D, then a stray ack
    next_cycle(); d_req = 1; d_addr = 32'h500; mid();
    chk("t5_d_ready", p_d_ready, 1);
    next_cycle(); d_req = 0; mid();
    chk("t5_mem_addr", p_mem_addr, 32'h500);
    next_cycle(); rst = 1; mid();
    next_cycle(); rst = 0; mem_ack = 1; mem_rdata = L5; mid();
    chk("t5_mem_req", p_mem_req, 0);
    chk("t5_mem_addr_rst", p_mem_addr, 0);
    chk("t5_d_rdata_rst", p_d_rdata, 0);
    chk("t5_i_rdata_rst", p_i_rdata, 0);
    next_cycle(); mem_ack = 0; mid();
    chk("t5_no_d_rvalid", p_d_rvalid, 0);
    chk("t5_d_rdata_ign", p_d_rdata, 0);
    chk("t5_mem_req_ign", p_mem_req, 0);
    next_cycle(); i_req = 1; i_addr = 32'h600; mid();
    chk("t5_i_ready", p_i_ready, 1);
    next_cycle(); i_req = 0; mem_ack = 1; mem_rdata = L5; mid();
    chk("t5_mem_addr_i", p_mem_addr, 32'h600);

    // 6: acks during DONE and IDLE are ignored
    next_cycle(); mem_ack = 1; mem_rdata = L6; mid();
    chk("t6_i_rvalid_done", p_i_rvalid, 1);
    chk("t6_i_rdata_done", p_i_rdata, L5);
    next_cycle(); mid();
    chk("t6_i_rvalid_idle", p_i_rvalid, 0);
    chk("t6_i_rdata_idle", p_i_rdata, L5);
    chk("t6_mem_req_idle", p_mem_req, 0);
    next_cycle(); mem_ack = 0; mid();
    chk("t6_rvalid_after", p_i_rvalid | p_d_rvalid, 0);
    chk("t6_mem_req_after", p_mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
